// File: rtl/ram_burst_master.sv
// ram_burst_master: burst initiator for one port of a dual-port synchronous RAM.
// Accepts read/write burst requests, walks wrapping addresses onto the RAM port,
// and realigns the RAM's one-cycle read latency into a valid/last response stream.
module ram_burst_master #(
  parameter int address_length = 4,
  parameter int word_length    = 64,
  parameter int len_width      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  // request channel
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [address_length-1:0] req_addr,
  input  logic [len_width-1:0]      req_len,
  // write beat stream
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  input  logic [word_length-1:0]    wdata,
  // read beat stream (no backpressure)
  output logic                      rdata_valid,
  output logic [word_length-1:0]    rdata,
  output logic                      rdata_last,
  // burst completion pulse
  output logic                      done,
  // RAM port
  output logic [address_length-1:0] ram_address,
  output logic [word_length-1:0]    ram_data,
  output logic                      ram_wren,
  input  logic [word_length-1:0]    ram_q
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  localparam logic [address_length-1:0] addr_one = 1;
  localparam logic [len_width-1:0]      len_one  = 1;

  state_t                    state;
  state_t                    state_next;
  logic [address_length-1:0] addr_cnt;   // next write beat address
  logic [len_width-1:0]      beat_cnt;   // beats remaining minus one
  logic                      req_fire;
  logic                      wbeat_fire;
  logic                      beat_last;
  logic                      read_issue;
  logic                      issue_d;    // read issued last cycle -> data on ram_q now
  logic                      last_d;     // final read issued last cycle
  logic                      wr_done;    // final write beat presented this cycle

  assign req_fire   = req_valid & req_ready;
  assign wbeat_fire = wdata_valid & wdata_ready;
  assign beat_last  = (beat_cnt == '0);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_fire) state_next = req_write ? WRITE : READ;
      READ:    if (beat_last) state_next = IDLE;
      WRITE:   if (wr_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and issue decode from the current state.
  always_comb begin
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    read_issue  = 1'b0;
    case (state)
      IDLE:    req_ready   = ~reset;
      READ:    read_issue  = 1'b1;
      WRITE:   wdata_ready = ~wr_done;  // all beats taken once the last write is presented
      default: ;
    endcase
  end

  // Address/beat counters, registered RAM drive and read-return alignment.
  // NOTE: every flop here is in the async reset so a mid-burst reset kills ram_wren at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_cnt    <= '0;
      beat_cnt    <= '0;
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      issue_d     <= 1'b0;
      last_d      <= 1'b0;
      wr_done     <= 1'b0;
    end else begin
      ram_wren <= wbeat_fire;
      issue_d  <= read_issue;
      last_d   <= read_issue & beat_last;
      wr_done  <= wbeat_fire & beat_last;
      if (req_fire) begin
        addr_cnt    <= req_addr;
        ram_address <= req_addr;
        beat_cnt    <= req_len;
      end else if (read_issue) begin
        if (!beat_last) begin
          ram_address <= ram_address + addr_one;
          beat_cnt    <= beat_cnt - len_one;
        end
      end else if (wbeat_fire) begin
        ram_address <= addr_cnt;
        ram_data    <= wdata;
        addr_cnt    <= addr_cnt + addr_one;
        if (!beat_last) beat_cnt <= beat_cnt - len_one;
      end
    end
  end

  // Read response stream: RAM data passes straight through, qualified by the delayed issue.
  always_comb begin
    rdata_valid = issue_d;
    rdata_last  = last_d;
    rdata       = ram_q;
    done        = last_d | wr_done;
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: self-checking bench with a behavioural RAM and a
// shadow-memory reference model of burst semantics.
module tb_ram_burst_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [2:0]  req_len;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [63:0] wdata;
  logic        rdata_valid;
  logic [63:0] rdata;
  logic        rdata_last;
  logic        done;
  logic [3:0]  ram_address;
  logic [63:0] ram_data;
  logic        ram_wren;
  logic [63:0] ram_q;

  logic [63:0] mem[16];      // the RAM being driven
  logic [63:0] exp_mem[16];  // what the bench believes the RAM holds

  int errors = 0;
  int checks = 0;

  ram_burst_master #(
    .address_length(4),
    .word_length   (64),
    .len_width     (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready),
    .wdata      (wdata),
    .rdata_valid(rdata_valid),
    .rdata      (rdata),
    .rdata_last (rdata_last),
    .done       (done),
    .ram_address(ram_address),
    .ram_data   (ram_data),
    .ram_wren   (ram_wren),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency, write commits at the clock edge.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] beat_word(input logic [3:0] nib, input int n);
    logic [3:0] v;
    v = nib + 4'(n);
    return {16{v}};
  endfunction

  // Present a request and wait (bounded) for acceptance; returns in cycle 1.
  task automatic issue_req(input logic wr, input logic [3:0] a, input logic [2:0] l, output bit ok);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = l;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("req_accepted", ok, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_read(input logic [3:0] a, input logic [2:0] l,
                          input int chk_beat, input logic [63:0] chk_word);
    bit ok;
    int n;
    logic [3:0] ea;
    issue_req(1'b0, a, l, ok);
    for (int c = 1; c <= int'(l) + 2; c++) begin
      @(negedge clk);
      if (c <= int'(l) + 1) begin
        ea = 4'(int'(a) + c - 1);
        check("rd_addr", ram_address, ea);
      end
      check("rd_valid", rdata_valid, c >= 2);
      if (c >= 2) begin
        n  = c - 2;
        ea = 4'(int'(a) + n);
        check("rd_data", rdata, exp_mem[ea]);
        if (n == chk_beat) check("rd_vector", rdata, chk_word);
      end
      check("rd_last", rdata_last, c == int'(l) + 2);
      check("rd_done", done, c == int'(l) + 2);
      check("rd_req_ready", req_ready, c == int'(l) + 2);
      check("rd_no_wren", ram_wren, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_write(input logic [3:0] a, input logic [2:0] l, input logic [3:0] nib,
                           input logic [63:0] salt, input int stall);
    bit ok;
    bit prev_fire = 1'b0;
    bit fin = 1'b0;
    int beat = 0;
    int wait_cnt = 0;
    int prev_beat = 0;
    logic [3:0]  prev_addr = '0;
    logic [63:0] prev_word = '0;
    issue_req(1'b1, a, l, ok);
    for (int c = 1; c < 60 && !fin; c++) begin
      if (beat <= int'(l) && wait_cnt == 0) begin
        wdata_valid = 1'b1;
        wdata       = beat_word(nib, beat) ^ salt;
      end else begin
        wdata_valid = 1'b0;
        wdata       = {$urandom, $urandom};
      end
      if (wait_cnt > 0) wait_cnt--;
      @(negedge clk);
      check("wr_wren", ram_wren, prev_fire);
      if (prev_fire) begin
        check("wr_addr", ram_address, prev_addr);
        check("wr_data", ram_data, prev_word);
      end
      check("wr_done", done, prev_fire && prev_beat == int'(l));
      check("wr_ready", wdata_ready, beat <= int'(l));
      check("wr_req_busy", req_ready, 1'b0);
      if (prev_fire && prev_beat == int'(l)) fin = 1'b1;
      prev_fire = wdata_valid && beat <= int'(l);
      if (prev_fire) begin
        prev_addr = 4'(int'(a) + beat);
        prev_word = wdata;
        prev_beat = beat;
        exp_mem[prev_addr] = wdata;
        beat++;
        wait_cnt = stall;
      end
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    check("wr_finished", fin, 1'b1);
    @(negedge clk);
    check("wr_req_ready_after", req_ready, 1'b1);
    check("wr_wren_after", ram_wren, 1'b0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [2:0]  len;
    logic [3:0]  nib;       // write data pattern: beat n = {16{nib+n}}
    int          stall;     // idle cycles between write beats
    int          chk_beat;  // read beat with a fixed expected word (-1 none)
    logic [63:0] chk_word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    logic [63:0] old6;

    vecs[0] = '{1'b0, 4'h0, 3'd0, 4'h0, 0,  0, 64'hFEEDFACECAFEBABE};
    vecs[1] = '{1'b1, 4'hA, 3'd3, 4'hA, 0, -1, 64'h0};
    vecs[2] = '{1'b0, 4'hA, 3'd3, 4'h0, 0,  3, 64'hDDDDDDDDDDDDDDDD};
    vecs[3] = '{1'b0, 4'hE, 3'd3, 4'h0, 0,  2, 64'hFEEDFACECAFEBABE};
    vecs[4] = '{1'b1, 4'h1, 3'd1, 4'h5, 2, -1, 64'h0};
    vecs[5] = '{1'b0, 4'h1, 3'd1, 4'h0, 0,  1, 64'h6666666666666666};
    vecs[6] = '{1'b1, 4'hF, 3'd7, 4'h1, 0, -1, 64'h0};
    vecs[7] = '{1'b0, 4'hF, 3'd7, 4'h0, 0,  1, 64'h2222222222222222};

    for (int i = 0; i < 16; i++) begin
      mem[i]     = {8{8'(i * 17 + 3)}};
      exp_mem[i] = {8{8'(i * 17 + 3)}};
    end
    mem[0]     = 64'hFEEDFACECAFEBABE;
    exp_mem[0] = 64'hFEEDFACECAFEBABE;

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_len     = '0;
    wdata_valid = 1'b0;
    wdata       = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_wdata_ready", wdata_ready, 1'b0);
    check("rst_rdata_valid", rdata_valid, 1'b0);
    check("rst_rdata_last", rdata_last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ram_wren", ram_wren, 1'b0);
    check("rst_ram_address", ram_address, 4'h0);
    check("rst_ram_data", ram_data, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    // Directed burst table.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) run_write(vecs[i].addr, vecs[i].len, vecs[i].nib, 64'h0, vecs[i].stall);
      else            run_read(vecs[i].addr, vecs[i].len, vecs[i].chk_beat, vecs[i].chk_word);
    end

    // Second request held while an 8-beat read is busy.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'h3;
    req_len   = 3'd7;
    @(negedge clk);
    check("blk_first_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_addr = 4'h9;
    req_len  = 3'd1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("blk_req_ready", req_ready, c == 9);
      check("blk_done", done, c == 9);
      if (c >= 2) check("blk_rdata", rdata, exp_mem[4'(3 + c - 2)]);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("blk_second_addr", ram_address, 4'h9);
    @(posedge clk); #1;
    @(negedge clk);
    check("blk_second_valid0", rdata_valid, 1'b1);
    check("blk_second_data0", rdata, exp_mem[9]);
    check("blk_second_done0", done, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("blk_second_data1", rdata, exp_mem[10]);
    check("blk_second_last", rdata_last, 1'b1);
    check("blk_second_done1", done, 1'b1);
    @(posedge clk); #1;

    // Reset in the middle of a 4-beat write to 0x4.
    old6 = exp_mem[6];
    issue_req(1'b1, 4'h4, 3'd3, ok);
    for (int c = 1; c <= 3; c++) begin
      wdata_valid = 1'b1;
      wdata       = beat_word(4'h7, c - 1);
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    exp_mem[4] = beat_word(4'h7, 0);
    exp_mem[5] = beat_word(4'h7, 1);
    check("rstw_pre_wren", ram_wren, 1'b1);
    reset = 1'b1;
    #1;
    check("rstw_wren", ram_wren, 1'b0);
    check("rstw_wdata_ready", wdata_ready, 1'b0);
    check("rstw_done", done, 1'b0);
    check("rstw_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstw_release_ready", req_ready, 1'b1);
    check("rstw_release_wren", ram_wren, 1'b0);
    @(posedge clk); #1;
    run_read(4'h4, 3'd2, 2, old6);

    // Randomized bursts against the shadow model.
    for (int i = 0; i < 24; i++) begin
      logic [3:0] ra;
      logic [2:0] rl;
      ra = 4'($urandom_range(0, 15));
      rl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        run_write(ra, rl, 4'($urandom_range(0, 15)), {$urandom, $urandom}, int'($urandom_range(0, 2)));
      else
        run_read(ra, rl, -1, 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
# ram_burst_master

Initiator for one port of the dual-port memory (`two_port_ram`). It accepts read or write burst requests from a core-side client over a valid/ready handshake and sequences consecutive, wrapping addresses onto the RAM port. On reads it realigns the RAM's one-cycle synchronous read data into a response stream marked with valid and last flags. It sits between a core's load/store or line-fill logic and one RAM port, so two instances can share the RAM, one per port.

## Interface
- `address_length`, 4, RAM address width; must match the RAM.
- `word_length`, 64, data word width; must match the RAM.
- `len_width`, 3, burst length field width; a burst is `req_len+1` beats, 1..8 by default.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid & req_ready`.
- `req_write` in 1: 1 = write burst, 0 = read burst.
- `req_addr` in `address_length`: first beat address.
- `req_len` in `len_width`: beats minus one.
- `wdata_valid` in 1, `wdata_ready` out 1, `wdata` in `word_length`: write beat stream.
- `rdata_valid` out 1, `rdata` out `word_length`, `rdata_last` out 1: read beat stream; no backpressure.
- `done` out 1: one-cycle pulse when a burst completes.
- `ram_address` out `address_length`, `ram_data` out `word_length`, `ram_wren` out 1: registered RAM port drive.
- `ram_q` in `word_length`: RAM read data, valid the cycle after the RAM samples `ram_address`.

## Operation
- FSM states: IDLE, READ, WRITE.
- IDLE:
  - `req_ready = ~reset`.
  - On acceptance, latch `req_addr` into the address counter and `req_len` into the beat counter.
  - Go to READ or WRITE per `req_write`.
- READ:
  - Each cycle, `ram_address` holds the current beat address.
  - Counter increments modulo 2^`address_length`, so 0xF is followed by 0x0.
  - After `req_len+1` issue cycles, return to IDLE.
- Read return path:
  - One-cycle delayed issue flag drives `rdata_valid`.
  - `rdata = ram_q`, combinational pass-through.
  - `rdata_last` marks the final beat.
- WRITE:
  - `wdata_ready = 1` while beats remain.
  - Each accepted beat registers `ram_address`, `ram_data`, `ram_wren=1` for the next cycle; the RAM commits at the end of that cycle.
  - Cycles with no accepted beat give `ram_wren=0` the next cycle; the address does not advance.
  - After the last beat is accepted, `wdata_ready=0`.
- `done`:
  - Read burst: asserted with the last `rdata_valid` beat.
  - Write burst: asserted in the cycle the last `ram_wren=1` is presented.
- `req_ready = 0` outside IDLE; requests presented then are held by the client, not dropped.
- `wdata_valid` is ignored outside WRITE.

## Timing
- Reset values:
  - State IDLE.
  - `req_ready=0` while `reset` is high; 1 in the first cycle after deassertion.
  - `wdata_ready=0`, `rdata_valid=0`, `rdata_last=0`, `done=0`.
  - `ram_wren=0`, `ram_address=0`, `ram_data=0`.
- Reset mid-burst aborts immediately:
  - `ram_wren` drops asynchronously.
  - No further beats or `done`.
  - Uncommitted write beats are lost.
- Read burst accepted at edge 0:
  - `ram_address = A` in cycle 1.
  - Beat n: `rdata_valid=1` in cycle 2+n with data of address (A+n) mod 2^`address_length`.
  - `rdata_last` and `done` in cycle 2+len.
  - `req_ready=1` again from cycle 2+len.
  - Minimum request-to-request spacing is len+2 cycles.
- Write burst accepted at edge 0:
  - `wdata_ready=1` from cycle 1.
  - Beat accepted in cycle k gives `ram_wren=1` in cycle k+1; data is readable from cycle k+2.
  - Back-to-back `wdata_valid` gives one write per cycle.
  - `req_ready=1` in the cycle after `done`.
- `req_len=0` gives single-beat bursts with identical timing.
- `len_width`-bit maximum (7) gives 8 beats.
- Address wrap has no effect on timing.

## Test plan
- Single read, post-reset init: after reset, read `req_addr=0x0`, `req_len=0`.
  - Requires `rdata=FEEDFACECAFEBABE` with `rdata_valid`, `rdata_last`, `done` all in cycle 2.
- Write then read-back: write 4 beats at 0xA of `AAAA…AAAA`, `BBBB…BBBB`, `CCCC…CCCC`, `DDDD…DDDD` with continuous `wdata_valid`.
  - Requires `ram_wren` high for 4 consecutive cycles at addresses 0xA–0xD.
  - `done` with the 4th write.
  - A following 4-beat read returns the same words in order, last beat flagged.
- Wrap-around: 4-beat read from 0xE.
  - Requires `ram_address` sequence 0xE, 0xF, 0x0, 0x1.
  - Third beat equals `FEEDFACECAFEBABE`.
- Write stall: 2-beat write at 0x1 with `wdata_valid` low for 2 cycles between beats.
  - Requires `ram_wren` pulses separated by 2 idle cycles.
  - Second write lands at 0x2, with no address skip.
  - Read-back of 0x1 and 0x2 matches.
- Request blocked while busy: hold `req_valid` high with a second request during an 8-beat read.
  - Requires `req_ready=0` throughout.
  - Second request accepted the cycle `done` is seen.
- Reset mid-write: assert `reset` after beat 2 of a 4-beat write to 0x4.
  - Requires `ram_wren`, `wdata_ready`, `done` all 0 immediately.
  - Address 0x6 unchanged; `req_ready=1` one cycle after release.
